// File: rtl/led_ctrl_if.sv
// Register-map side of the LED controller: per-LED mode, timing controls,
// one-shot strobes and the one-shot status readback.
interface led_ctrl_if #(
  parameter int PRESC_W = 16,
  parameter int NLED    = 8
);
  logic [2*NLED-1:0]  led_mode;
  logic [PRESC_W-1:0] presc_div;
  logic [7:0]         pwm_duty;
  logic [7:0]         blink_half;
  logic [NLED-1:0]    led_pulse;
  logic [NLED-1:0]    led_pulse_sts;

  modport master (
    output led_mode, presc_div, pwm_duty, blink_half, led_pulse,
    input  led_pulse_sts
  );

  modport slave (
    input  led_mode, presc_div, pwm_duty, blink_half, led_pulse,
    output led_pulse_sts
  );
endinterface

// File: rtl/led_ctrl.sv
// Drives the board LEDs as off/on/blink/PWM, with a retriggerable one-shot
// override per LED. All timing derives from one shared prescaler tick.
module led_ctrl #(
  parameter int PRESC_W = 16,
  parameter int NLED    = 8
) (
  input  logic            clk,
  input  logic            res,
  led_ctrl_if.slave       regs,
  output logic [NLED-1:0] led
);

  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         pwm_cnt;
  logic [7:0]         blink_cnt;
  logic               blink_phase;
  logic [8:0]         pulse_cnt [NLED];

  logic               tick;
  logic               period_end;
  logic               pwm_on;
  logic [8:0]         pulse_nxt [NLED];
  logic [NLED-1:0]    sts_nxt;
  logic [NLED-1:0]    led_nxt;

  // Using >= instead of == keeps the counters from running off to their full
  // wrap when presc_div is lowered below the current count.
  always_comb begin
    tick       = (presc_cnt >= regs.presc_div);
    period_end = tick && (pwm_cnt == 8'hFF);
    pwm_on     = (pwm_cnt < regs.pwm_duty);
    for (int i = 0; i < NLED; i++) begin
      pulse_nxt[i] = pulse_cnt[i];
      if (regs.led_pulse[i]) begin
        pulse_nxt[i] = 9'd256;
      end else if (tick && (pulse_cnt[i] != 9'd0)) begin
        pulse_nxt[i] = pulse_cnt[i] - 9'd1;
      end
      sts_nxt[i] = (pulse_nxt[i] != 9'd0);
      unique case (regs.led_mode[2*i +: 2])
        2'b00:   led_nxt[i] = 1'b0;
        2'b01:   led_nxt[i] = 1'b1;
        2'b10:   led_nxt[i] = blink_phase;
        default: led_nxt[i] = pwm_on;
      endcase
      led_nxt[i] = led_nxt[i] | sts_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      presc_cnt          <= '0;
      pwm_cnt            <= '0;
      blink_cnt          <= '0;
      blink_phase        <= 1'b0;
      led                <= '0;
      regs.led_pulse_sts <= '0;
      for (int i = 0; i < NLED; i++) begin
        pulse_cnt[i] <= '0;
      end
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (period_end) begin
        if (blink_cnt >= regs.blink_half) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
      for (int i = 0; i < NLED; i++) begin
        pulse_cnt[i] <= pulse_nxt[i];
      end
      led                <= led_nxt;
      regs.led_pulse_sts <= sts_nxt;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: directed scenarios plus randomized runs, each cycle
// checked against a tick-counting model of the LED behaviour.
module tb_led_ctrl;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] led;

  led_ctrl_if #(.PRESC_W(16), .NLED(8)) regs ();

  led_ctrl #(.PRESC_W(16), .NLED(8)) dut (
    .clk  (clk),
    .res  (res),
    .regs (regs),
    .led  (led)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   fails  = 0;

  // Model: total ticks since reset, prescaler position, and the tick count at
  // which each LED's one-shot was last loaded.
  int   m_presc;
  int   m_ticks;
  int   load_t   [8];
  bit   has_load [8];
  logic [7:0] exp_led;
  logic [7:0] exp_sts;

  // Predicts the outputs after the coming edge, then advances one clock.
  task automatic step();
    bit   tk;
    bit   pon;
    bit   ph;
    bit   act;
    bit   src;
    int   nt;
    if (res) begin
      m_presc = 0;
      m_ticks = 0;
      for (int i = 0; i < 8; i++) has_load[i] = 1'b0;
      exp_led = '0;
      exp_sts = '0;
    end else begin
      tk  = (m_presc >= int'(regs.presc_div));
      pon = ((m_ticks % 256) < int'(regs.pwm_duty));
      ph  = (((m_ticks / 256) / (int'(regs.blink_half) + 1)) % 2) == 1;
      nt  = m_ticks + (tk ? 1 : 0);
      for (int i = 0; i < 8; i++) begin
        if (regs.led_pulse[i]) begin
          has_load[i] = 1'b1;
          load_t[i]   = nt;
        end
        act = has_load[i] && ((nt - load_t[i]) < 256);
        case (regs.led_mode[2*i +: 2])
          2'b00:   src = 1'b0;
          2'b01:   src = 1'b1;
          2'b10:   src = ph;
          default: src = pon;
        endcase
        exp_sts[i] = act;
        exp_led[i] = act | src;
      end
      m_presc = tk ? 0 : m_presc + 1;
      m_ticks = nt;
    end
    @(posedge clk);
    #1;
    regs.led_pulse = '0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    step();
    res = 1'b0;
  endtask

  task automatic test_reset();
    regs.led_mode  = 16'h5555;
    regs.presc_div = 16'd0;
    res = 1'b1;
    step();
    step();
    checks++;
    if ({led, regs.led_pulse_sts} !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_outputs led=%h sts=%h expected 00/00", led, regs.led_pulse_sts);
    end
    res = 1'b0;
    step();
    checks++;
    if (led !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL reset_release_on led=%h expected ff", led);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duties [3] = '{8'd64, 8'd0, 8'd255};
    int hi;
    for (int d = 0; d < 3; d++) begin
      regs.led_mode  = 16'hFFFF;
      regs.presc_div = 16'd0;
      regs.pwm_duty  = duties[d];
      do_reset();
      hi = 0;
      for (int c = 0; c < 512; c++) begin
        step();
        if (led[0]) hi++;
        checks++;
        if ({led, regs.led_pulse_sts} !== {exp_led, exp_sts}) begin
          fails++;
          $display("[TB] FAIL pwm_cycle duty=%0d c=%0d led=%h sts=%h expected %h/%h",
                   duties[d], c, led, regs.led_pulse_sts, exp_led, exp_sts);
        end
      end
      checks++;
      if (hi !== 2 * int'(duties[d])) begin
        fails++;
        $display("[TB] FAIL pwm_high_count duty=%0d got %0d expected %0d", duties[d], hi, 2 * int'(duties[d]));
      end
    end
  endtask

  task automatic test_blink();
    int first_hi;
    regs.led_mode   = 16'h0002;
    regs.presc_div  = 16'd1;
    regs.blink_half = 8'd2;
    do_reset();
    first_hi = -1;
    for (int c = 1; c <= 3200; c++) begin
      step();
      if (led[0] && first_hi < 0) first_hi = c;
      checks++;
      if ({led, regs.led_pulse_sts} !== {exp_led, exp_sts}) begin
        fails++;
        $display("[TB] FAIL blink_cycle c=%0d led=%h expected %h", c, led, exp_led);
      end
    end
    checks++;
    if (first_hi !== 1537) begin
      fails++;
      $display("[TB] FAIL blink_first_toggle got cycle %0d expected 1537", first_hi);
    end
  endtask

  // Runs until led_pulse_sts[0] drops, returning how many cycles it was high.
  task automatic run_pulse(input int pre_high, input int retrig_at, output int hi);
    hi = pre_high;
    for (int c = 0; c < 5000; c++) begin
      if (c == retrig_at) regs.led_pulse = 8'h01;
      step();
      checks++;
      if ({led, regs.led_pulse_sts} !== {exp_led, exp_sts}) begin
        fails++;
        $display("[TB] FAIL pulse_cycle c=%0d led=%h sts=%h expected %h/%h",
                 c, led, regs.led_pulse_sts, exp_led, exp_sts);
      end
      if (!regs.led_pulse_sts[0]) break;
      hi++;
    end
  endtask

  task automatic test_pulse();
    int hi;
    int guard;
    regs.led_mode  = 16'h0000;
    regs.presc_div = 16'd9;
    do_reset();
    regs.led_pulse = 8'h01;
    run_pulse(0, -1, hi);
    checks++;
    if (hi < 2551 || hi > 2560) begin
      fails++;
      $display("[TB] FAIL pulse_length got %0d expected 2551..2560", hi);
    end

    do_reset();
    regs.led_pulse = 8'h01;
    run_pulse(0, 1000, hi);
    checks++;
    if (hi < 3551 || hi > 3560) begin
      fails++;
      $display("[TB] FAIL pulse_retrigger_length got %0d expected 3551..3560", hi);
    end

    do_reset();
    step();
    step();
    step();
    guard = 0;
    while (m_presc != 9 && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      fails++;
      $display("[TB] FAIL pulse_tick_align timed out after %0d cycles", guard);
    end
    regs.led_pulse = 8'h01;
    run_pulse(0, -1, hi);
    checks++;
    if (hi !== 2560) begin
      fails++;
      $display("[TB] FAIL pulse_on_tick_length got %0d expected 2560", hi);
    end
  endtask

  task automatic test_reset_mid();
    regs.led_mode   = 16'($urandom);
    regs.presc_div  = 16'd0;
    regs.pwm_duty   = 8'($urandom_range(1, 254));
    regs.blink_half = 8'd0;
    do_reset();
    regs.led_pulse = 8'hFF;
    for (int c = 0; c < 200; c++) step();
    res = 1'b1;
    step();
    res = 1'b0;
    checks++;
    if ({led, regs.led_pulse_sts} !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_mid_outputs led=%h sts=%h expected 00/00", led, regs.led_pulse_sts);
    end
    for (int c = 0; c < 600; c++) begin
      step();
      checks++;
      if ({led, regs.led_pulse_sts} !== {exp_led, exp_sts}) begin
        fails++;
        $display("[TB] FAIL reset_mid_restart c=%0d led=%h expected %h", c, led, exp_led);
      end
    end
  endtask

  task automatic test_presc_change();
    regs.led_mode  = 16'hFFFF;
    regs.pwm_duty  = 8'd1;
    regs.presc_div = 16'd1000;
    do_reset();
    for (int c = 0; c < 500; c++) step();
    regs.presc_div = 16'd5;
    step();
    checks++;
    if (led !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL presc_lower_first led=%h expected ff", led);
    end
    step();
    checks++;
    if (led !== 8'h00) begin
      fails++;
      $display("[TB] FAIL presc_lower_tick led=%h expected 00", led);
    end
    for (int c = 0; c < 100; c++) begin
      if (c == 20) regs.pwm_duty = 8'd4;
      step();
      checks++;
      if ({led, regs.led_pulse_sts} !== {exp_led, exp_sts}) begin
        fails++;
        $display("[TB] FAIL presc_lower_run c=%0d led=%h expected %h", c, led, exp_led);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      regs.led_mode   = 16'($urandom);
      regs.presc_div  = 16'($urandom_range(0, 3));
      regs.pwm_duty   = 8'($urandom);
      regs.blink_half = 8'($urandom_range(0, 1));
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 63) == 0) regs.led_pulse = 8'($urandom);
        if ($urandom_range(0, 255) == 0) regs.pwm_duty = 8'($urandom);
        if ($urandom_range(0, 255) == 0) regs.led_mode = 16'($urandom);
        if ($urandom_range(0, 511) == 0) regs.presc_div = 16'($urandom_range(0, 3));
        step();
        checks++;
        if ({led, regs.led_pulse_sts} !== {exp_led, exp_sts}) begin
          fails++;
          $display("[TB] FAIL random_cycle r=%0d c=%0d led=%h sts=%h expected %h/%h",
                   r, c, led, regs.led_pulse_sts, exp_led, exp_sts);
        end
      end
    end
  endtask

  initial begin
    res             = 1'b1;
    regs.led_mode   = '0;
    regs.presc_div  = '0;
    regs.pwm_duty   = '0;
    regs.blink_half = '0;
    regs.led_pulse  = '0;
    #1;
    test_reset();
    test_pwm();
    test_blink();
    test_pulse();
    test_reset_mid();
    test_presc_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Output-side counterpart of the board I/O interrupt logic: drives the 8 board LEDs from register-map controls.
- Each LED is independently off, on, blinking or PWM-dimmed. It can also be briefly forced on by a retriggerable one-shot pulse.
- Sits between the register map and the LED pins. All timing derives from one shared prescaler tick.

Parameters:
- PRESC_W, 16, width of the prescaler divider and counter.
- NLED, 8, number of LEDs driven.

Ports:
- clk  input  1  system clock
- res  input  1  synchronous reset, active-high
- led_mode  input  2*NLED  per LED i, bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM
- presc_div  input  PRESC_W  tick every presc_div+1 clk cycles
- pwm_duty  input  8  shared PWM duty, on-count out of 256
- blink_half  input  8  PWM periods per blink half-period, minus one
- led_pulse  input  NLED  single-cycle strobe per LED: start or retrigger the one-shot
- led  output  NLED  LED pins, registered
- led_pulse_sts  output  NLED  1 while the one-shot for that LED is active

Behaviour:
- All state updates on the rising edge of clk. While res=1:
  - presc_cnt=0, pwm_cnt=0, blink_cnt=0, blink_phase=0.
  - All pulse counters 0.
  - led=0, led_pulse_sts=0.
- Prescaler:
  - presc_cnt counts 0..presc_div, then wraps to 0.
  - tick=1 in the cycle presc_cnt==presc_div.
  - presc_div=0 gives tick every cycle.
  - If presc_div is lowered below presc_cnt, wrap at the next compare-equal is not guaranteed. Instead, presc_cnt>=presc_div also produces tick and wraps to 0.
- PWM:
  - 8-bit pwm_cnt increments on tick, 255 -> 0.
  - pwm_on = (pwm_cnt < pwm_duty), unsigned compare.
  - duty 0 -> never on. Duty 255 -> on 255 of 256 ticks.
  - Duty changes take effect on the next compare; there is no period-boundary shadowing.
- Blink:
  - period_end = tick && pwm_cnt==255.
  - On period_end: if blink_cnt==blink_half, then blink_cnt=0 and blink_phase toggles. Otherwise blink_cnt++.
  - Same >= protection as the prescaler if blink_half is lowered mid-count.
- One-shot, per LED i, 9-bit pulse_cnt[i]:
  - led_pulse[i]=1 loads 256, regardless of mode and whether already active (retrigger).
  - Otherwise, on tick with pulse_cnt[i]!=0, decrement.
  - led_pulse_sts[i] = (pulse_cnt[i]!=0), registered.
  - A strobe coincident with a decrementing tick: the load wins.
- LED output:
  - led[i] next value = pulse active ? 1 : mode-selected source.
  - Sources: 00 -> 0, 01 -> 1, 10 -> blink_phase, 11 -> pwm_on.
- Latency:
  - One clk from a led_mode change to led.
  - One clk from a led_pulse strobe to led=1 and led_pulse_sts=1.
  - The one-shot stays on for exactly 256 ticks after the load, then drops.
- All LEDs share the counters, so LEDs in the same mode are phase-aligned.
- Reset asserted mid-operation aborts everything within one cycle. After release, counting restarts from 0.
- No interrupt or handshake: inputs are level registers sampled every cycle, except led_pulse, which is a strobe.

Test Plan:
- Reset, then led_mode=16'h5555, presc_div=0 -> led=8'h00 during res, and led=8'hFF one clk after res falls.
- led_mode=16'hFFFF, presc_div=0, pwm_duty=64 -> each LED high for 64 of every 256 cycles, phase-aligned. Repeat with duty 0 (always 0) and duty 255 (one low cycle per 256).
- led_mode[1:0]=10, presc_div=1, blink_half=2 -> led[0] toggles every 3*256*2=1536 clk. First toggle after reset at cycle 1536, within the one-cycle output latency.
- presc_div=9, led_mode=0, led_pulse=8'h01 for one cycle -> led[0]=1 and led_pulse_sts[0]=1 for 2560 clk (±one tick phase), then 0.
  - Retrigger at 1000 cycles: the high time extends to 1000 + ~2560.
  - Strobe coincident with a tick: reload to 256 is observed.
- Assert res for one cycle in the middle of the PWM/blink/pulse run -> every output reads 0 the cycle after. The PWM pattern restarts from pwm_cnt=0.
- presc_div changed from 1000 to 5 while presc_cnt≈500 -> tick fires on the next cycle and the prescaler then runs at period 6, with no 2^16 wrap.
